// File: rtl/v_act_pkg.sv
// Shared types and the per-lane activation function for the leaky-ReLU stream stage.
// The lane function works at a fixed wide width so any element width up to 32 bits can use it.
package v_act_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    RELU   = 2'd1,
    LEAKY  = 2'd2
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    EMIT = 2'd2
  } fsm_state_e;

  localparam int ACC_W = 32;

  // Code 3 is reserved and behaves as LEAKY.
  function automatic act_mode_e decode_mode(input logic [1:0] mode);
    case (mode)
      2'd0:    return BYPASS;
      2'd1:    return RELU;
      default: return LEAKY;
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] act_lane(
    input logic signed [ACC_W-1:0] x,
    input act_mode_e               mode,
    input logic [4:0]              shift
  );
    logic signed [ACC_W-1:0] y;
    y = x;
    if (x < 0) begin
      case (mode)
        BYPASS:  y = x;
        RELU:    y = '0;
        default: y = x >>> shift;
      endcase
    end
    return y;
  endfunction

endpackage

// File: rtl/vec_ring_buf.sv
// Ring buffer of whole vectors with a show-ahead head output (zero while empty).
// Pop on empty is ignored; push on full is only taken when a pop frees the slot in the same cycle.
module vec_ring_buf
  import v_act_pkg::*;
#(
  parameter int VecElements = 16,
  parameter int NBits       = 12,
  parameter int Depth       = 2
) (
  input  logic                                clk,
  input  logic                                srst,
  input  logic                                push,
  input  logic [VecElements-1:0][NBits-1:0]   push_data,
  input  logic                                pop,
  output logic                                full,
  output logic                                empty,
  output logic [VecElements-1:0][NBits-1:0]   head
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);

  logic [VecElements-1:0][NBits-1:0] mem [Depth];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(Depth));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/v_leakyrelu_stream.sv
// Streaming vector leaky-ReLU stage: input buffer -> chunked in-place transform -> output buffer.
// One vector every NCH+1 cycles; mode is latched when a vector leaves the input buffer.
module v_leakyrelu_stream
  import v_act_pkg::*;
#(
  parameter int VecElements   = 16,
  parameter int ChunkElements = 4,
  parameter int NBits         = 12,
  parameter int SlopeShift    = 3,
  parameter int InDepth       = 2,
  parameter int OutDepth      = 2,
  parameter int CountBits     = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              in_data_ready,
  input  logic [VecElements-1:0][NBits-1:0] in_data_top,
  input  logic [1:0]                        mode_in,
  input  logic                              rd_out_top,
  output logic                              module_ready,
  output logic                              out_data_valid,
  output logic [VecElements-1:0][NBits-1:0] out_data_top,
  output logic                              busy,
  output logic [CountBits-1:0]              vec_count,
  output logic                              drop_err
);

  localparam int NCH = VecElements / ChunkElements;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW  = (VecElements > 1) ? $clog2(VecElements) : 1;

  typedef logic [VecElements-1:0][NBits-1:0] vec_t;

  fsm_state_e           state_reg, state_next;
  vec_t                 work_reg, work_next;
  logic [CHW-1:0]       chunk_reg, chunk_next;
  act_mode_e            mode_reg, mode_next;
  logic [CountBits-1:0] vec_count_reg;
  logic                 drop_err_reg;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push;
  vec_t in_head, out_head;

  assign in_push = in_data_ready && !in_full;

  vec_ring_buf #(
    .VecElements(VecElements),
    .NBits      (NBits),
    .Depth      (InDepth)
  ) u_in_buf (
    .clk      (clk_in),
    .srst     (rst_in),
    .push     (in_push),
    .push_data(in_data_top),
    .pop      (in_pop),
    .full     (in_full),
    .empty    (in_empty),
    .head     (in_head)
  );

  vec_ring_buf #(
    .VecElements(VecElements),
    .NBits      (NBits),
    .Depth      (OutDepth)
  ) u_out_buf (
    .clk      (clk_in),
    .srst     (rst_in),
    .push     (out_push),
    .push_data(work_reg),
    .pop      (rd_out_top),
    .full     (out_full),
    .empty    (out_empty),
    .head     (out_head)
  );

  // Only the ChunkElements lanes of the current chunk go through the activation each cycle.
  logic [LW-1:0]          lane_idx [ChunkElements];
  logic signed [NBits-1:0] lane_res [ChunkElements];

  for (genvar gi = 0; gi < ChunkElements; gi++) begin : g_lane
    assign lane_idx[gi] = LW'(int'(chunk_reg) * ChunkElements + gi);
    assign lane_res[gi] = NBits'(act_lane(ACC_W'(signed'(work_reg[lane_idx[gi]])),
                                          mode_reg, 5'(SlopeShift)));
  end

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    chunk_next = chunk_reg;
    mode_next  = mode_reg;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!in_empty) begin
          in_pop     = 1'b1;
          work_next  = in_head;
          mode_next  = decode_mode(mode_in);
          chunk_next = '0;
          state_next = PROC;
        end
      end
      PROC: begin
        for (int i = 0; i < ChunkElements; i++) begin
          work_next[lane_idx[i]] = lane_res[i];
        end
        chunk_next = chunk_reg + 1'b1;
        if (chunk_reg == CHW'(NCH - 1)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        // A full output buffer holds the finished vector here until space opens.
        if (!out_full) begin
          out_push = 1'b1;
          if (!in_empty) begin
            in_pop     = 1'b1;
            work_next  = in_head;
            mode_next  = decode_mode(mode_in);
            chunk_next = '0;
            state_next = PROC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      chunk_reg     <= '0;
      mode_reg      <= BYPASS;
      vec_count_reg <= '0;
      drop_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      chunk_reg <= chunk_next;
      mode_reg  <= mode_next;
      if (out_push) begin
        vec_count_reg <= vec_count_reg + 1'b1;
      end
      if (in_data_ready && in_full) begin
        drop_err_reg <= 1'b1;
      end
    end
  end

  assign module_ready   = !in_full;
  assign out_data_valid = !out_empty;
  assign out_data_top   = out_head;
  assign busy           = (state_reg != IDLE);
  assign vec_count      = vec_count_reg;
  assign drop_err       = drop_err_reg;

endmodule

// File: tb/tb_v_leakyrelu_stream.sv
// Directed bench for v_leakyrelu_stream: per-mode arithmetic, latency, backpressure,
// drop detection, output stall, continuous streaming and mid-operation reset.
module tb_v_leakyrelu_stream;

  localparam int VE = 16;
  localparam int CE = 4;
  localparam int NB = 12;
  localparam int CB = 16;
  localparam int VW = VE * NB;

  typedef logic [VE-1:0][NB-1:0] vec_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          in_data_ready = 1'b0;
  vec_t          in_data_top = '0;
  logic [1:0]    mode_in = 2'd0;
  logic          rd_out_top = 1'b0;
  logic          module_ready;
  logic          out_data_valid;
  vec_t          out_data_top;
  logic          busy;
  logic [CB-1:0] vec_count;
  logic          drop_err;

  always #5 clk_in = ~clk_in;

  v_leakyrelu_stream #(
    .VecElements  (VE),
    .ChunkElements(CE),
    .NBits        (NB),
    .SlopeShift   (3),
    .InDepth      (2),
    .OutDepth     (2),
    .CountBits    (CB)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_data_ready (in_data_ready),
    .in_data_top   (in_data_top),
    .mode_in       (mode_in),
    .rd_out_top    (rd_out_top),
    .module_ready  (module_ready),
    .out_data_valid(out_data_valid),
    .out_data_top  (out_data_top),
    .busy          (busy),
    .vec_count     (vec_count),
    .drop_err      (drop_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Hand-computed lanes: LEAKY is floor(x/8) for negatives, RELU zeroes them.
  int t_in    [VE] = '{-64, -7, -1, 0, 5, 2047, -2048, -9, 15, -16, -17, 1, -2, 300, -300, 7};
  int t_leaky [VE] = '{ -8, -1, -1, 0, 5, 2047,  -256, -2, 15,  -2,  -3, 1, -1, 300,  -38, 7};
  int t_relu  [VE] = '{  0,  0,  0, 0, 5, 2047,     0,  0, 15,   0,   0, 1,  0, 300,    0, 7};

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic vec_t mk_vec(input int a[VE]);
    vec_t v;
    for (int i = 0; i < VE; i++) v[i] = NB'(a[i]);
    return v;
  endfunction

  function automatic vec_t seq_vec(input int k);
    vec_t v;
    for (int i = 0; i < VE; i++) v[i] = NB'(k * 37 + i * 5 - 60);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!out_data_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, out_data_valid, 1'b1);
  endtask

  task automatic pop_expect(input string tag, input vec_t exp);
    wait_valid(tag, 30);
    check_eq(tag, out_data_top, exp);
    rd_out_top = 1'b1;
    tick();
    rd_out_top = 1'b0;
  endtask

  task automatic push_one(input vec_t v);
    in_data_top   = v;
    in_data_ready = 1'b1;
    tick();
    in_data_ready = 1'b0;
  endtask

  initial begin
    int n;
    int sent;
    int rcvd;
    int cyc;

    // Reset state
    do_reset();
    check_eq("rst_ready", module_ready, 1'b1);
    check_eq("rst_valid", out_data_valid, 1'b0);
    check_eq("rst_data", out_data_top, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_count", vec_count, '0);
    check_eq("rst_drop", drop_err, 1'b0);

    // LEAKY single vector with exact latency; mode changes after the pop must not matter
    mode_in = 2'd2;
    push_one(mk_vec(t_in));          // E0
    tick();                          // E1: popped, mode latched
    mode_in = 2'd0;
    repeat (4) tick();               // E5
    check_eq("leaky_lat_e5", out_data_valid, 1'b0);
    check_eq("leaky_busy", busy, 1'b1);
    tick();                          // E6
    check_eq("leaky_lat_e6", out_data_valid, 1'b1);
    check_eq("leaky_data", out_data_top, mk_vec(t_leaky));
    rd_out_top = 1'b1;
    tick();
    rd_out_top = 1'b0;
    check_eq("leaky_popped", out_data_valid, 1'b0);
    check_eq("leaky_count", vec_count, CB'(1));

    // RELU, BYPASS, reserved code 3
    mode_in = 2'd1;
    push_one(mk_vec(t_in));
    pop_expect("relu_data", mk_vec(t_relu));
    mode_in = 2'd0;
    push_one(mk_vec(t_in));
    pop_expect("bypass_data", mk_vec(t_in));
    mode_in = 2'd3;
    push_one(mk_vec(t_in));
    pop_expect("mode3_data", mk_vec(t_leaky));
    check_eq("modes_count", vec_count, CB'(4));

    // Backpressure, drop detection and output-full stall
    do_reset();
    mode_in = 2'd0;
    in_data_ready = 1'b1;
    in_data_top = seq_vec(0); tick();
    in_data_top = seq_vec(1); tick();
    in_data_top = seq_vec(2); tick();
    in_data_ready = 1'b0;
    check_eq("fill_ready_low", module_ready, 1'b0);
    check_eq("fill_no_drop", drop_err, 1'b0);
    n = 0;
    while (!module_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("fill_ready_back", module_ready, 1'b1);
    push_one(seq_vec(3));
    check_eq("fill_full_again", module_ready, 1'b0);
    push_one(seq_vec(4));            // dropped
    check_eq("fill_drop_err", drop_err, 1'b1);
    repeat (12) tick();
    check_eq("stall_busy", busy, 1'b1);
    check_eq("stall_count", vec_count, CB'(2));
    check_eq("stall_head", out_data_top, seq_vec(0));
    rd_out_top = 1'b1;
    tick();
    rd_out_top = 1'b0;
    check_eq("stall_pop_edge", vec_count, CB'(2));
    tick();
    check_eq("stall_emit_next", vec_count, CB'(3));
    pop_expect("drain_1", seq_vec(1));
    pop_expect("drain_2", seq_vec(2));
    pop_expect("drain_3", seq_vec(3));
    repeat (3) tick();
    check_eq("drain_empty", out_data_valid, 1'b0);
    check_eq("drain_idle", busy, 1'b0);
    check_eq("drain_count", vec_count, CB'(4));
    check_eq("drain_drop_sticky", drop_err, 1'b1);

    // Continuous streaming with pops held high
    do_reset();
    mode_in = 2'd0;
    rd_out_top = 1'b1;
    sent = 0;
    rcvd = 0;
    cyc = 0;
    while (rcvd < 10 && cyc < 400) begin
      if (sent < 10 && module_ready) begin
        in_data_top = seq_vec(sent + 10);
        in_data_ready = 1'b1;
        sent++;
      end else begin
        in_data_ready = 1'b0;
      end
      @(negedge clk_in);
      if (out_data_valid) begin
        check_eq($sformatf("stream_%0d", rcvd), out_data_top, seq_vec(rcvd + 10));
        rcvd++;
      end
      tick();
      cyc++;
    end
    in_data_ready = 1'b0;
    rd_out_top = 1'b0;
    check_eq("stream_received", rcvd, 10);
    check_eq("stream_no_drop", drop_err, 1'b0);
    check_eq("stream_count", vec_count, CB'(10));

    // Reset while processing with two vectors buffered
    do_reset();
    mode_in = 2'd2;
    in_data_ready = 1'b1;
    in_data_top = seq_vec(20); tick();
    in_data_top = seq_vec(21); tick();
    in_data_top = seq_vec(22); tick();
    in_data_ready = 1'b0;
    check_eq("midrst_pre_busy", busy, 1'b1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_eq("midrst_ready", module_ready, 1'b1);
    check_eq("midrst_valid", out_data_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_count", vec_count, '0);
    check_eq("midrst_data", out_data_top, '0);
    repeat (15) tick();
    check_eq("midrst_stale_valid", out_data_valid, 1'b0);
    check_eq("midrst_stale_count", vec_count, '0);
    check_eq("midrst_stale_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
